// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI slave types, widths, response codes and FSM states
package axi_pkg;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_LEN_W = 4;
  localparam int AXI_SIZE_W = 3;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
endpackage

// File: rtl/axi_modport_slave_if.sv
// axi_modport_slave_if: AXI3 bus bundle (AW/W/B/AR/R) with master and slave modports
interface axi_modport_slave_if #(parameter int ADDR_WIDTH = 32, parameter int ID_WIDTH = 4);
  import axi_pkg::*;
  logic [ID_WIDTH-1:0] AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [AXI_LEN_W-1:0] AWLEN;
  logic [AXI_SIZE_W-1:0] AWSIZE;
  logic [1:0] AWBURST;
  logic AWVALID, AWREADY;
  logic [ID_WIDTH-1:0] WID;
  logic [AXI_DATA_W-1:0] WDATA;
  logic [AXI_STRB_W-1:0] WSTRB;
  logic WLAST, WVALID, WREADY;
  logic [ID_WIDTH-1:0] BID;
  logic [1:0] BRESP;
  logic BVALID, BREADY;
  logic [ID_WIDTH-1:0] ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [AXI_LEN_W-1:0] ARLEN;
  logic [AXI_SIZE_W-1:0] ARSIZE;
  logic [1:0] ARBURST;
  logic ARVALID, ARREADY;
  logic [ID_WIDTH-1:0] RID;
  logic [AXI_DATA_W-1:0] RDATA;
  logic [1:0] RRESP;
  logic RLAST, RVALID, RREADY;
  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational next-beat address, burst legality and memory range check
// i_addr/i_len/i_size/i_burst: current beat address and burst fields
// o_next: next beat address; o_idx: word index; o_burst_err: illegal burst; o_in_range: address inside memory
module axi_burst_addr import axi_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [AXI_LEN_W-1:0] i_len,
  input  logic [AXI_SIZE_W-1:0] i_size,
  input  logic [1:0] i_burst,
  output logic [ADDR_WIDTH-1:0] o_next,
  output logic [$clog2(MEM_DEPTH)-1:0] o_idx,
  output logic o_burst_err,
  output logic o_in_range
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);
  logic [ADDR_WIDTH-1:0] w_bytes, w_incr, w_span, w_lower;
  logic [ADDR_WIDTH:0] w_off;
  always_comb begin
    w_bytes = ONE << i_size;
    w_incr = (i_addr & ~(w_bytes - ONE)) + w_bytes;
    // legal wrap spans are powers of two, so masking gives the lower boundary
    w_span = (ADDR_WIDTH'(i_len) + ONE) * w_bytes;
    w_lower = i_addr & ~(w_span - ONE);
    o_next = i_burst == BURST_FIXED ? i_addr
           : (i_burst == BURST_WRAP && w_incr == w_lower + w_span) ? w_lower : w_incr;
    o_burst_err = i_size > 3'd2 || i_burst == 2'b11
               || (i_burst == BURST_WRAP && !(i_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    // extra top bit catches addresses below the base
    w_off = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    o_in_range = !w_off[ADDR_WIDTH] && w_off[ADDR_WIDTH-1:0] < LIMIT;
    o_idx = w_off[IDX_W+1:2];
  end
endmodule

// File: rtl/axi_modport_slave.sv
// axi_modport_slave: AXI3 memory-backed slave with independent single-burst write and read FSMs
// ACLK: clock; ARESETn: async active-low reset; s_axi: slave modport of the AXI bus
module axi_modport_slave import axi_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic ACLK,
  input logic ARESETn,
  axi_modport_slave_if.slave s_axi
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  wstate_e r_wstate, w_wstate_nxt;
  rstate_e r_rstate, w_rstate_nxt;
  logic [ID_WIDTH-1:0] r_wid, r_rid;
  logic [ADDR_WIDTH-1:0] r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;
  logic [AXI_LEN_W-1:0] r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic [AXI_SIZE_W-1:0] r_wsize, r_rsize;
  logic [1:0] r_wburst, r_rburst;
  logic [IDX_W-1:0] w_widx, w_ridx;
  logic r_werr, r_rerr, w_wburst_err, w_rburst_err, w_win_range, w_rin_range;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wlast_beat, w_rlast_beat, w_werr_now, w_rerr_now;
  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_waddr (
    .i_addr(r_waddr), .i_len(r_wlen), .i_size(r_wsize), .i_burst(r_wburst),
    .o_next(w_waddr_nxt), .o_idx(w_widx), .o_burst_err(w_wburst_err), .o_in_range(w_win_range)
  );
  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_raddr (
    .i_addr(r_raddr), .i_len(r_rlen), .i_size(r_rsize), .i_burst(r_rburst),
    .o_next(w_raddr_nxt), .o_idx(w_ridx), .o_burst_err(w_rburst_err), .o_in_range(w_rin_range)
  );
  always_comb begin
    // address-ready is gated by reset so it stays low while ARESETn is asserted
    s_axi.AWREADY = ARESETn && r_wstate == W_IDLE;
    s_axi.WREADY = r_wstate == W_DATA;
    s_axi.BVALID = r_wstate == W_RESP;
    s_axi.BID = r_wid;
    s_axi.BRESP = (r_wstate == W_RESP && r_werr) ? RESP_SLVERR : RESP_OKAY;
    w_aw_hs = s_axi.AWVALID && ARESETn && r_wstate == W_IDLE;
    w_w_hs = s_axi.WVALID && r_wstate == W_DATA;
    w_b_hs = s_axi.BREADY && r_wstate == W_RESP;
    w_wlast_beat = r_wcnt == r_wlen;
    // any bad beat poisons the rest of the burst and blocks its memory write
    w_werr_now = r_werr || w_wburst_err || !w_win_range || s_axi.WID != r_wid || s_axi.WLAST != w_wlast_beat;
    w_wstate_nxt = w_aw_hs ? W_DATA : (w_w_hs && w_wlast_beat) ? W_RESP : w_b_hs ? W_IDLE : r_wstate;
    s_axi.ARREADY = ARESETn && r_rstate == R_IDLE;
    s_axi.RVALID = r_rstate == R_DATA;
    s_axi.RID = r_rid;
    w_rlast_beat = r_rcnt == r_rlen;
    w_rerr_now = r_rerr || w_rburst_err || !w_rin_range;
    s_axi.RLAST = r_rstate == R_DATA && w_rlast_beat;
    s_axi.RRESP = (r_rstate == R_DATA && w_rerr_now) ? RESP_SLVERR : RESP_OKAY;
    s_axi.RDATA = (r_rstate == R_DATA && !w_rerr_now) ? r_mem[w_ridx] : '0;
    w_ar_hs = s_axi.ARVALID && ARESETn && r_rstate == R_IDLE;
    w_r_hs = s_axi.RREADY && r_rstate == R_DATA;
    w_rstate_nxt = w_ar_hs ? R_DATA : (w_r_hs && w_rlast_beat) ? R_IDLE : r_rstate;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
      r_wid <= '0;
      r_waddr <= '0;
      r_wlen <= '0;
      r_wsize <= '0;
      r_wburst <= '0;
      r_wcnt <= '0;
      r_werr <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_wid <= s_axi.AWID;
        r_waddr <= s_axi.AWADDR;
        r_wlen <= s_axi.AWLEN;
        r_wsize <= s_axi.AWSIZE;
        r_wburst <= s_axi.AWBURST;
        r_wcnt <= '0;
        r_werr <= 1'b0;
      end else if (w_w_hs) begin
        r_waddr <= w_waddr_nxt;
        r_wcnt <= r_wcnt + AXI_LEN_W'(1);
        r_werr <= w_werr_now;
      end
    end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_rstate <= R_IDLE;
      r_rid <= '0;
      r_raddr <= '0;
      r_rlen <= '0;
      r_rsize <= '0;
      r_rburst <= '0;
      r_rcnt <= '0;
      r_rerr <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rid <= s_axi.ARID;
        r_raddr <= s_axi.ARADDR;
        r_rlen <= s_axi.ARLEN;
        r_rsize <= s_axi.ARSIZE;
        r_rburst <= s_axi.ARBURST;
        r_rcnt <= '0;
        r_rerr <= 1'b0;
      end else if (w_r_hs) begin
        r_raddr <= w_raddr_nxt;
        r_rcnt <= r_rcnt + AXI_LEN_W'(1);
        r_rerr <= w_rerr_now;
      end
    end
  always_ff @(posedge ACLK)
    for (int b = 0; b < AXI_STRB_W; b++)
      if (w_w_hs && !w_werr_now && s_axi.WSTRB[b]) r_mem[w_widx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
endmodule

// File: tb/tb_axi_modport_slave.sv
// tb_axi_modport_slave: directed self-checking bench for axi_modport_slave
module tb_axi_modport_slave;
  logic ACLK, ARESETn;
  int checks = 0;
  int errors = 0;
  axi_modport_slave_if bus ();
  axi_modport_slave dut (.ACLK(ACLK), .ARESETn(ARESETn), .s_axi(bus));
  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1;
    while (!bus.AWREADY && n < 20) begin @(negedge ACLK); n++; end
    check("awready", bus.AWREADY, 1);
    @(negedge ACLK);
    bus.AWVALID = 0;
  endtask
  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst; bus.ARVALID = 1;
    while (!bus.ARREADY && n < 20) begin @(negedge ACLK); n++; end
    check("arready", bus.ARREADY, 1);
    @(negedge ACLK);
    bus.ARVALID = 0;
  endtask
  task automatic wbeat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.WID = id; bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1;
    while (!bus.WREADY && n < 20) begin @(negedge ACLK); n++; end
    check("wready", bus.WREADY, 1);
    @(negedge ACLK);
    bus.WVALID = 0; bus.WLAST = 0;
  endtask
  task automatic bresp(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    while (!bus.BVALID && n < 20) begin @(negedge ACLK); n++; end
    check("bvalid", bus.BVALID, 1);
    check("bid", bus.BID, id);
    check("bresp", bus.BRESP, resp);
    bus.BREADY = 1;
    @(negedge ACLK);
    bus.BREADY = 0;
    check("b_single", bus.BVALID, 0);
  endtask
  task automatic rbeat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last, input int stall);
    int n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge ACLK); n++; end
    check("rvalid", bus.RVALID, 1);
    check("rid", bus.RID, id);
    check("rdata", bus.RDATA, data);
    check("rresp", bus.RRESP, resp);
    check("rlast", bus.RLAST, last);
    for (int i = 0; i < stall; i++) begin
      @(negedge ACLK);
      check("rdata_stall", bus.RDATA, data);
      check("rvalid_stall", bus.RVALID, 1);
    end
    bus.RREADY = 1;
    @(negedge ACLK);
    bus.RREADY = 0;
  endtask
  initial begin
    ARESETn = 0;
    bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0; bus.ARVALID = 0; bus.RREADY = 0;
    bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
    bus.WID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.WLAST = 0;
    bus.ARID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;
    repeat (2) @(negedge ACLK);
    check("rst_awready", bus.AWREADY, 0);
    check("rst_wready", bus.WREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_bid", bus.BID, 0);
    check("rst_bresp", bus.BRESP, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_rresp", bus.RRESP, 0);
    check("rst_rdata", bus.RDATA, 0);
    ARESETn = 1;
    @(negedge ACLK);
    check("idle_awready", bus.AWREADY, 1);
    check("idle_arready", bus.ARREADY, 1);
    aw(4'h5, 32'h10, 4'd0, 3'd2, 2'b01);
    wbeat(4'h5, 32'hDEADBEEF, 4'hF, 1);
    bresp(4'h5, 2'b00);
    ar(4'h3, 32'h10, 4'd0, 3'd2, 2'b01);
    rbeat(4'h3, 32'hDEADBEEF, 2'b00, 1, 0);
    aw(4'h2, 32'h100, 4'd3, 3'd2, 2'b01);
    wbeat(4'h2, 32'd1, 4'hF, 0);
    wbeat(4'h2, 32'd2, 4'hF, 0);
    wbeat(4'h2, 32'd3, 4'hF, 0);
    wbeat(4'h2, 32'd4, 4'hF, 1);
    bresp(4'h2, 2'b00);
    ar(4'h6, 32'h100, 4'd3, 3'd2, 2'b01);
    rbeat(4'h6, 32'd1, 2'b00, 0, 0);
    rbeat(4'h6, 32'd2, 2'b00, 0, 3);
    rbeat(4'h6, 32'd3, 2'b00, 0, 0);
    rbeat(4'h6, 32'd4, 2'b00, 1, 0);
    aw(4'h7, 32'h108, 4'd3, 3'd2, 2'b10);
    wbeat(4'h7, 32'hA0, 4'hF, 0);
    wbeat(4'h7, 32'hA1, 4'hF, 0);
    wbeat(4'h7, 32'hA2, 4'hF, 0);
    wbeat(4'h7, 32'hA3, 4'hF, 1);
    bresp(4'h7, 2'b00);
    ar(4'h1, 32'h100, 4'd3, 3'd2, 2'b01);
    rbeat(4'h1, 32'hA2, 2'b00, 0, 0);
    rbeat(4'h1, 32'hA3, 2'b00, 0, 0);
    rbeat(4'h1, 32'hA0, 2'b00, 0, 0);
    rbeat(4'h1, 32'hA1, 2'b00, 1, 0);
    ar(4'h9, 32'h108, 4'd3, 3'd2, 2'b10);
    rbeat(4'h9, 32'hA0, 2'b00, 0, 0);
    rbeat(4'h9, 32'hA1, 2'b00, 0, 0);
    rbeat(4'h9, 32'hA2, 2'b00, 0, 0);
    rbeat(4'h9, 32'hA3, 2'b00, 1, 0);
    aw(4'h8, 32'h20, 4'd0, 3'd2, 2'b01);
    wbeat(4'h8, 32'h11223344, 4'hF, 1);
    bresp(4'h8, 2'b00);
    aw(4'h8, 32'h20, 4'd0, 3'd2, 2'b01);
    wbeat(4'h8, 32'hAABBCCDD, 4'b0101, 1);
    bresp(4'h8, 2'b00);
    ar(4'h8, 32'h20, 4'd0, 3'd2, 2'b01);
    rbeat(4'h8, 32'h11BB33DD, 2'b00, 1, 0);
    aw(4'h4, 32'hFFC, 4'd0, 3'd2, 2'b01);
    wbeat(4'h4, 32'hCAFEF00D, 4'hF, 1);
    bresp(4'h4, 2'b00);
    ar(4'h4, 32'hFFC, 4'd0, 3'd2, 2'b01);
    rbeat(4'h4, 32'hCAFEF00D, 2'b00, 1, 0);
    aw(4'hA, 32'h1010, 4'd0, 3'd2, 2'b01);
    wbeat(4'hA, 32'h0BADF00D, 4'hF, 1);
    bresp(4'hA, 2'b10);
    aw(4'hB, 32'h10, 4'd0, 3'd2, 2'b11);
    wbeat(4'hB, 32'h12345678, 4'hF, 1);
    bresp(4'hB, 2'b10);
    ar(4'hC, 32'h10, 4'd0, 3'd2, 2'b01);
    rbeat(4'hC, 32'hDEADBEEF, 2'b00, 1, 0);
    ar(4'hD, 32'h1010, 4'd0, 3'd2, 2'b01);
    rbeat(4'hD, 32'h0, 2'b10, 1, 0);
    aw(4'h1, 32'h200, 4'd3, 3'd2, 2'b01);
    wbeat(4'h1, 32'h77, 4'hF, 0);
    ARESETn = 0;
    #1;
    check("midrst_awready", bus.AWREADY, 0);
    check("midrst_wready", bus.WREADY, 0);
    check("midrst_bvalid", bus.BVALID, 0);
    @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    check("post_awready", bus.AWREADY, 1);
    check("post_wready", bus.WREADY, 0);
    for (int i = 0; i < 4; i++) begin
      check("post_no_b", bus.BVALID, 0);
      @(negedge ACLK);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
